// File: rtl/alu_frame_sequencer_if.sv
// Byte-stream, TX-handshake and adder-operand signals around the ALU frame sequencer.
// The master modport is the sequencer side; slave is the UART/adder side.
interface alu_frame_sequencer_if #(
  parameter int N = 16
);
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         busy;
  logic         frame_err;

  modport master (
    input  rx_data, rx_valid, tx_busy, alu_result, alu_flags,
    output tx_data, tx_start, alu_a, alu_b, busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, alu_result, alu_flags,
    input  tx_data, tx_start, alu_a, alu_b, busy, frame_err
  );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Frames UART bytes into adder operands, returns sum + {V,N,Z,P}; ALU_SEQ_CHECKSUM_EN appends an XOR byte.
// First tx_start 2 cycles after the last operand byte; each TX byte waits for tx_busy low.
module alu_frame_sequencer #(
  parameter int         N              = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_frame_sequencer_if.master bus
);
  localparam int BYTES = N / 8;
`ifdef ALU_SEQ_CHECKSUM_EN
  localparam int OUT_BYTES = BYTES + 2;
`else
  localparam int OUT_BYTES = BYTES + 1;
`endif
  localparam int OW = OUT_BYTES * 8;
  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] LAST_OP = CW'(BYTES - 1);
  localparam logic [CW-1:0] OUT_CNT = CW'(OUT_BYTES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_A     = 3'd1;
  localparam logic [2:0] S_RX_B     = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_TX_SEND  = 3'd4;
  localparam logic [2:0] S_TX_GUARD = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [OW-1:0] txbuf_q, txbuf_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          ferr_q, ferr_d;
  logic [OW-1:0] frame_w;

`ifdef ALU_SEQ_CHECKSUM_EN
  logic [7:0] csum_w;
  always_comb begin
    csum_w = {4'b0000, bus.alu_flags};
    for (int i = 0; i < BYTES; i++) begin
      csum_w = csum_w ^ bus.alu_result[i*8 +: 8];
    end
  end
  assign frame_w = {bus.alu_result, 4'b0000, bus.alu_flags, csum_w};
`else
  assign frame_w = {bus.alu_result, 4'b0000, bus.alu_flags};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    a_d        = a_q;
    b_d        = b_q;
    txbuf_d    = txbuf_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    ferr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d = S_RX_A;
          busy_d  = 1'b1;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      S_RX_A, S_RX_B: begin
        if (bus.rx_valid) begin
          to_d = '0;
          if (state_q == S_RX_A) a_d = (a_q << 8) | N'(bus.rx_data);
          else                   b_d = (b_q << 8) | N'(bus.rx_data);
          if (cnt_q == LAST_OP) begin
            cnt_d   = '0;
            state_d = (state_q == S_RX_A) ? S_RX_B : S_EXEC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_q == TO_LAST) begin
          // Abort keeps partial operands; only control state is unwound.
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ferr_d  = 1'b1;
          to_d    = '0;
          cnt_d   = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_EXEC: begin
        txbuf_d = frame_w;
        cnt_d   = '0;
        state_d = S_TX_SEND;
      end
      S_TX_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d  = txbuf_q[OW-1 -: 8];
          txbuf_d    = txbuf_q << 8;
          tx_start_d = 1'b1;
          cnt_d      = cnt_q + CW'(1);
          state_d    = S_TX_GUARD;
        end
      end
      S_TX_GUARD: begin
        if (cnt_q == OUT_CNT) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_TX_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      txbuf_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      a_q        <= a_d;
      b_q        <= b_d;
      txbuf_q    <= txbuf_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Bench for alu_frame_sequencer: vector table of frames, scoreboard of TX bytes, UART busy model.
module tb_alu_frame_sequencer;
  localparam int N  = 16;
  localparam int TO = 16;
  localparam int NV = 7;
`ifdef ALU_SEQ_CHECKSUM_EN
  localparam int OUT = 4;
`else
  localparam int OUT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_frame_sequencer_if #(.N(N)) bus();

  alu_frame_sequencer #(
    .N(N),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Adder model: V = signed overflow, P = even parity of the sum.
  assign bus.alu_result = bus.alu_a + bus.alu_b;
  assign bus.alu_flags  = {(bus.alu_a[N-1] == bus.alu_b[N-1]) && (bus.alu_result[N-1] != bus.alu_a[N-1]),
                           bus.alu_result[N-1], bus.alu_result == '0, ~^bus.alu_result};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic [7:0]  flags;
  } vec_t;

  vec_t       tbl[NV];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       hold = 1'b0;
  int         bcnt = 0;
  int         rx_last = 0;
  logic [7:0] exp_q[$];
  int         tx_cycles[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // TX monitor and UART busy model: busy rises the negedge after each tx_start.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        tx_cycles.push_back(cyc);
        chk("tx_start_while_busy", {31'd0, bus.tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got=%0h want=none (cycle %0d)", bus.tx_data, cyc);
        end else begin
          chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        end
        bcnt = 4;
      end else if (bcnt > 0) begin
        bcnt--;
      end
      bus.tx_busy = hold || (bcnt > 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rx_last      = cyc;
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back(v.r_hi);
    exp_q.push_back(v.r_lo);
    exp_q.push_back(v.flags);
`ifdef ALU_SEQ_CHECKSUM_EN
    exp_q.push_back(v.r_hi ^ v.r_lo ^ v.flags);
`endif
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
  endtask

  task automatic wait_done(output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL busy_stuck: got=1 want=0 (cycle %0d)", cyc);
    end
    repeat (8) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int base;
    int fall;
    push_exp(v);
    base = tx_cycles.size();
    send_frame(v.a, v.b);
    chk({tag, "_busy_high"}, {31'd0, bus.busy}, 32'd1);
    wait_done(fall);
    chk({tag, "_tx_count"}, tx_cycles.size() - base, OUT);
    if (tx_cycles.size() > base) begin
      chk({tag, "_latency"}, tx_cycles[base] - rx_last, 2);
      chk({tag, "_busy_fall"}, fall - tx_cycles[tx_cycles.size()-1], 1);
    end
    chk({tag, "_alu_a"}, {16'd0, bus.alu_a}, {16'd0, v.a});
    chk({tag, "_alu_b"}, {16'd0, bus.alu_b}, {16'd0, v.b});
  endtask

  initial begin
    int errc;
    int width;
    int base;
    logic [15:0] partial;

    tbl[0] = '{16'h0001, 16'h0002, 8'h00, 8'h03, 8'h01};
    tbl[1] = '{16'h7FFF, 16'h0001, 8'h80, 8'h00, 8'h0C};
    tbl[2] = '{16'hFFFF, 16'h0001, 8'h00, 8'h00, 8'h03};
    tbl[3] = '{16'h1234, 16'h4321, 8'h55, 8'h55, 8'h01};
    tbl[4] = '{16'h8000, 16'h8000, 8'h00, 8'h00, 8'h0B};
    tbl[5] = '{16'h00FF, 16'h0001, 8'h01, 8'h00, 8'h00};
    tbl[6] = '{16'hF0F0, 16'h0F0F, 8'hFF, 8'hFF, 8'h05};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, bus.alu_b}, 32'd0);

    for (int i = 0; i < NV; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Junk in IDLE, then a truncated frame that must time out.
    send_byte(8'h3C);
    chk("junk_busy0", {31'd0, bus.busy}, 32'd0);
    send_byte(8'h00);
    chk("junk_busy1", {31'd0, bus.busy}, 32'd0);
    send_byte(8'hA5);
    chk("sync_busy", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h12);
    errc  = -1;
    width = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_err) begin
        if (errc < 0) errc = cyc;
        width++;
      end
    end
    chk("timeout_delay", errc - rx_last, TO);
    chk("frame_err_width", width, 1);
    chk("timeout_busy", {31'd0, bus.busy}, 32'd0);
    partial = tbl[NV-1].a;
    partial = {partial[7:0], 8'h12};
    chk("timeout_alu_a_partial", {16'd0, bus.alu_a}, {16'd0, partial});
    chk("timeout_alu_b_hold", {16'd0, bus.alu_b}, {16'd0, tbl[NV-1].b});
    run_frame(tbl[0], "after_timeout");

    // Backpressure: transmitter held busy, bytes arriving mid-TX are dropped.
    hold = 1'b1;
    push_exp(tbl[1]);
    base = tx_cycles.size();
    send_frame(tbl[1].a, tbl[1].b);
    repeat (50) @(negedge clk);
    chk("bp_no_start", tx_cycles.size() - base, 0);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("bp_busy_held", {31'd0, bus.busy}, 32'd1);
    hold = 1'b0;
    wait_done(errc);
    chk("bp_tx_count", tx_cycles.size() - base, OUT);
    chk("bp_alu_a", {16'd0, bus.alu_a}, {16'd0, tbl[1].a});
    chk("bp_alu_b", {16'd0, bus.alu_b}, {16'd0, tbl[1].b});
    chk("bp_busy_after", {31'd0, bus.busy}, 32'd0);

    // Reset after the first TX byte abandons the rest of the frame.
    push_exp(tbl[2]);
    base = tx_cycles.size();
    send_frame(tbl[2].a, tbl[2].b);
    for (int i = 0; i < 20; i++) begin
      if (tx_cycles.size() > base) break;
      @(negedge clk);
    end
    chk("rst_mid_first_sent", tx_cycles.size() - base, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("rst_mid_no_more_tx", tx_cycles.size() - base, 1);
    chk("rst_mid_alu_a", {16'd0, bus.alu_a}, 32'd0);
    chk("rst_mid_alu_b", {16'd0, bus.alu_b}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    run_frame(tbl[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
